uart_prog_loader: RTL
=====================

# uart_prog_loader

Parametrised UART program loader that suspends the CPU, writes received bytes into program RAM and reboots the CPU when the load completes. It supports two modes: RAW, a headerless byte stream terminated by line idle, and FRAMED, which carries a header, load address, length and checksum. It sits between the board serial RX pin and the RAM write port / CPU-halt and CPU-reset logic, clocked by the RAM clock. It reuses the existing `uart_clk` and `uart_rx`.

## Interface
- `ADDR_WIDTH`, 16: width of `waddr`.
- `BASE_ADDR`, 16'h0600: first write address in RAW mode.
- `FRAMED`, 0: 0 selects RAW mode, 1 selects FRAMED mode.
- `IDLE_CYCLES`, 16'hFFFF: clk_ram cycles without a byte that end a RAW load or abort a FRAMED load.
- `BOOT_CYCLES`, 160: length of the `end_of_data` pulse, in cycles.
- `clk_ram` input 1: the only clock.
- `reset` input 1: asynchronous, active-high; all state clears immediately.
- `serial_rxd` input 1: UART line, idle high, asynchronous.
- `waddr` output ADDR_WIDTH: RAM write address.
- `wdata` output 8: RAM write data.
- `write_en` output 1: one-cycle RAM write strobe.
- `ask_for_ram` output 1: high suspends the CPU.
- `end_of_data` output 1: high holds the CPU in reset.
- `load_error` output 1: sticky flag for a failed FRAMED load.

## Operation
- `serial_rxd` passes through a 2-flop synchroniser; the synchronised signal feeds both `uart_rx` and the FSM.
- **Reset values:**
  - `waddr` = BASE_ADDR.
  - `wdata` = 0.
  - `write_en`, `ask_for_ram`, `end_of_data`, `load_error` = 0.
  - FSM in IDLE.
- **FSM states:** IDLE, HDR, ADR_LO, ADR_HI, LEN_LO, LEN_HI, DATA, CSUM, BOOT.
- **Start bit:** in any state except BOOT, synchronised rxd = 0 sets `ask_for_ram`.
- **RAW mode:**
  - IDLE→DATA on the first byte.
  - Every byte: `wdata` = byte, `write_en` pulses, `waddr` post-increments. The first byte is written at BASE_ADDR.
  - After IDLE_CYCLES with no new byte: DATA→BOOT.
- **FRAMED mode:**
  - IDLE: a byte of 8'hA5 clears `load_error` and moves to ADR_LO. Any other byte is discarded and `ask_for_ram` drops on the next cycle.
  - Next two bytes form the start address, little-endian. The two after that form the 16-bit payload length N, little-endian.
  - DATA writes N bytes from the start address and accumulates an 8-bit modular sum. N = 0 skips straight to CSUM.
  - CSUM: the checksum byte equal to the sum → BOOT. Mismatch → `load_error` = 1, `ask_for_ram` = 0, back to IDLE, no boot.
  - IDLE_CYCLES without a byte in any state from ADR_LO to CSUM → same abort path as a checksum mismatch.
- **BOOT:**
  - `ask_for_ram` = 0 and `end_of_data` = 1 for BOOT_CYCLES cycles, then → IDLE.
  - On entering IDLE, `waddr` returns to BASE_ADDR.
  - Start bits and bytes arriving during BOOT are ignored and dropped.
- `waddr` wraps modulo 2^ADDR_WIDTH. Address/length bytes wider than ADDR_WIDTH are truncated.
- The idle counter reloads on every received byte.

## Timing
- `write_en` is high for exactly the one cycle after `rx_data_strobe`. `waddr` and `wdata` are valid in that same cycle and hold afterwards.
- `ask_for_ram` rises 3 cycles after `serial_rxd` falls (2 synchroniser flops plus 1 register).
- RAW: BOOT begins IDLE_CYCLES cycles after the last strobe.
- FRAMED: BOOT begins the cycle after the checksum strobe.
- `end_of_data` is high for exactly BOOT_CYCLES cycles.
- The `ask_for_ram` fall and the `end_of_data` rise happen in the same cycle.
- Reset asserted mid-load or mid-BOOT: outputs take their reset values immediately and no further write occurs.

## Structure
- A shared package `prog_loader_pkg` holds the state encoding, the header constant 8'hA5 and the mode constants RAW = 0 and FRAMED = 1.
- Instantiates `uart_clk` and `uart_rx`; no new sub-module.
- The FSM, idle counter, boot counter, length counter and checksum accumulator all live in the top module.

## Test plan
- RAW, BASE_ADDR = 16'h0600: send 8'h11, 8'h22, 8'h33, then idle.
  - Expect three `write_en` pulses at 0600, 0601 and 0602 with data 11, 22, 33.
  - `end_of_data` high for 160 cycles exactly IDLE_CYCLES after the last strobe; `waddr` back to 0600 afterwards.
- FRAMED: send A5 00 02 03 00 AA BB CC 31.
  - Expect writes at 0200, 0201 and 0202 with AA, BB, CC, then BOOT.
  - `load_error` stays 0.
- FRAMED with a bad checksum 8'h32: same writes, then `load_error` = 1, `ask_for_ram` = 0, no `end_of_data`.
  - A following valid frame clears `load_error`.
- FRAMED N = 0: send A5 00 03 00 00 00 → no writes, BOOT.
- FRAMED, stream stops after the first payload byte: after IDLE_CYCLES expect `load_error` = 1, no boot.
- Reset asserted during BOOT in cycle 50: `end_of_data` drops within that cycle and all outputs hold their reset values.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding, frame header
// byte, load-mode constants and the UART oversample divider.
package prog_loader_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        ADR_LO,
        ADR_HI,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        BOOT
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam bit RAW    = 1'b0;
    localparam bit FRAMED = 1'b1;

    // clk_ram cycles per 16x-oversample tick; one UART bit is 16 ticks.
    localparam int unsigned UART_CLK_DIV = 4;

endpackage

// File: rtl/uart_clk.sv
// Baud tick generator: one-cycle tick every DIV clocks, used as the 16x
// oversample enable for uart_rx.
module uart_clk #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled. Emits the byte with a one-cycle
// rx_data_strobe in the middle of a valid stop bit.
module uart_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_data_strobe
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t  st;
    logic [3:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st             <= RX_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            rx_data        <= '0;
            rx_data_strobe <= 1'b0;
        end else begin
            rx_data_strobe <= 1'b0;
            if (tick) begin
                case (st)
                    RX_IDLE: begin
                        if (!rxd) begin
                            st  <= RX_START;
                            cnt <= '0;
                        end
                    end
                    RX_START: begin
                        // Re-check the start bit at mid-bit to reject glitches.
                        if (cnt == 4'd7) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            st      <= rxd ? RX_IDLE : RX_DATA;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (cnt == 4'd15) begin
                            cnt   <= '0;
                            shreg <= {rxd, shreg[7:1]};
                            if (bit_idx == 3'd7) st <= RX_STOP;
                            else                 bit_idx <= bit_idx + 3'd1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    RX_STOP: begin
                        if (cnt == 4'd15) begin
                            cnt <= '0;
                            st  <= RX_IDLE;
                            if (rxd) begin
                                rx_data        <= shreg;
                                rx_data_strobe <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    default: st <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: halts the CPU, streams received bytes into program RAM
// (RAW or FRAMED with address/length/checksum), then holds the CPU in reset.
module uart_prog_loader #(
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0600,
    parameter bit                    FRAMED      = 1'b0,
    parameter int unsigned           IDLE_CYCLES = 16'hFFFF,
    parameter int unsigned           BOOT_CYCLES = 160
) (
    input  logic                  clk_ram,
    input  logic                  reset,
    input  logic                  serial_rxd,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [7:0]            wdata,
    output logic                  write_en,
    output logic                  ask_for_ram,
    output logic                  end_of_data,
    output logic                  load_error
);

    import prog_loader_pkg::*;

    localparam bit IS_FRAMED = (FRAMED == prog_loader_pkg::FRAMED);
    localparam int IDLE_W    = $clog2(IDLE_CYCLES + 1);
    localparam int BOOT_W    = $clog2(BOOT_CYCLES + 1);

    logic       rxd_meta, rxd_sync;
    logic       tick;
    logic [7:0] rx_data;
    logic       rx_data_strobe;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   wptr, wptr_d, waddr_d;
    logic [7:0]              wdata_d, addr_lo, addr_lo_d, len_lo, len_lo_d, csum, csum_d;
    logic [15:0]             len_cnt, len_cnt_d;
    logic [IDLE_W-1:0]       idle_cnt, idle_cnt_d;
    logic [BOOT_W-1:0]       boot_cnt, boot_cnt_d;
    logic                    write_en_d, ask_d, eod_d, err_d;
    logic                    idle_expired, do_write, go_boot, go_abort;

    // Two-flop synchroniser; the line idles high so reset to 1.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= serial_rxd;
            rxd_sync <= rxd_meta;
        end
    end

    uart_clk #(.DIV(UART_CLK_DIV)) u_uart_clk (
        .clk   (clk_ram),
        .reset (reset),
        .tick  (tick)
    );

    uart_rx u_uart_rx (
        .clk            (clk_ram),
        .reset          (reset),
        .tick           (tick),
        .rxd            (rxd_sync),
        .rx_data        (rx_data),
        .rx_data_strobe (rx_data_strobe)
    );

    // idle_cnt holds the number of cycles since the last byte, saturating.
    assign idle_expired = (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        state_d    = state;
        wptr_d     = wptr;
        waddr_d    = waddr;
        wdata_d    = wdata;
        write_en_d = 1'b0;
        ask_d      = ask_for_ram;
        eod_d      = end_of_data;
        err_d      = load_error;
        addr_lo_d  = addr_lo;
        len_lo_d   = len_lo;
        len_cnt_d  = len_cnt;
        csum_d     = csum;
        boot_cnt_d = boot_cnt;
        do_write   = 1'b0;
        go_boot    = 1'b0;
        go_abort   = 1'b0;

        if (rx_data_strobe)    idle_cnt_d = IDLE_W'(1);
        else if (idle_expired) idle_cnt_d = idle_cnt;
        else                   idle_cnt_d = idle_cnt + IDLE_W'(1);

        if (!rxd_sync && state != BOOT) ask_d = 1'b1;

        case (state)
            IDLE: begin
                if (rx_data_strobe) begin
                    if (!IS_FRAMED) begin
                        do_write = 1'b1;
                        state_d  = DATA;
                    end else if (rx_data == HDR_BYTE) begin
                        err_d   = 1'b0;
                        csum_d  = '0;
                        state_d = ADR_LO;
                    end else begin
                        ask_d = 1'b0;
                    end
                end
            end
            ADR_LO: begin
                if (rx_data_strobe) begin
                    addr_lo_d = rx_data;
                    state_d   = ADR_HI;
                end else if (idle_expired) go_abort = 1'b1;
            end
            ADR_HI: begin
                if (rx_data_strobe) begin
                    wptr_d  = ADDR_WIDTH'({rx_data, addr_lo});
                    state_d = LEN_LO;
                end else if (idle_expired) go_abort = 1'b1;
            end
            LEN_LO: begin
                if (rx_data_strobe) begin
                    len_lo_d = rx_data;
                    state_d  = LEN_HI;
                end else if (idle_expired) go_abort = 1'b1;
            end
            LEN_HI: begin
                if (rx_data_strobe) begin
                    len_cnt_d = {rx_data, len_lo};
                    state_d   = ({rx_data, len_lo} == 16'd0) ? CSUM : DATA;
                end else if (idle_expired) go_abort = 1'b1;
            end
            DATA: begin
                if (rx_data_strobe) begin
                    do_write = 1'b1;
                    csum_d   = csum + rx_data;
                    if (IS_FRAMED) begin
                        len_cnt_d = len_cnt - 16'd1;
                        if (len_cnt == 16'd1) state_d = CSUM;
                    end
                end else if (idle_expired) begin
                    if (IS_FRAMED) go_abort = 1'b1;
                    else           go_boot  = 1'b1;
                end
            end
            CSUM: begin
                if (rx_data_strobe) begin
                    if (rx_data == csum) go_boot  = 1'b1;
                    else                 go_abort = 1'b1;
                end else if (idle_expired) go_abort = 1'b1;
            end
            BOOT: begin
                boot_cnt_d = boot_cnt + BOOT_W'(1);
                if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    eod_d      = 1'b0;
                    boot_cnt_d = '0;
                    wptr_d     = BASE_ADDR;
                    waddr_d    = BASE_ADDR;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_write) begin
            waddr_d    = wptr;
            wdata_d    = rx_data;
            write_en_d = 1'b1;
            wptr_d     = wptr + ADDR_WIDTH'(1);
        end
        if (go_boot) begin
            state_d    = BOOT;
            ask_d      = 1'b0;
            eod_d      = 1'b1;
            boot_cnt_d = '0;
        end
        if (go_abort) begin
            state_d = IDLE;
            err_d   = 1'b1;
            ask_d   = 1'b0;
            wptr_d  = BASE_ADDR;
            waddr_d = BASE_ADDR;
        end
    end

    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wptr        <= BASE_ADDR;
            waddr       <= BASE_ADDR;
            wdata       <= '0;
            write_en    <= 1'b0;
            ask_for_ram <= 1'b0;
            end_of_data <= 1'b0;
            load_error  <= 1'b0;
            addr_lo     <= '0;
            len_lo      <= '0;
            len_cnt     <= '0;
            csum        <= '0;
            idle_cnt    <= '0;
            boot_cnt    <= '0;
        end else begin
            state       <= state_d;
            wptr        <= wptr_d;
            waddr       <= waddr_d;
            wdata       <= wdata_d;
            write_en    <= write_en_d;
            ask_for_ram <= ask_d;
            end_of_data <= eod_d;
            load_error  <= err_d;
            addr_lo     <= addr_lo_d;
            len_lo      <= len_lo_d;
            len_cnt     <= len_cnt_d;
            csum        <= csum_d;
            idle_cnt    <= idle_cnt_d;
            boot_cnt    <= boot_cnt_d;
        end
    end

endmodule
